// File: rtl/dbus_uncached_responder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dbus_uncached_responder_pkg                                   |
// | Purpose  : Shared CPU data-bus definitions: physical address / word      |
// |            types, the dbus transaction-tag width and the responder FSM   |
// |            state encoding, plus a small byte-enable helper.              |
// | Ports    : none (package)                                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+

// Tag width shared by every dbus master/slave; overridable from the build.
`ifndef DBUS_TRANS_WIDTH
`define DBUS_TRANS_WIDTH 4
`endif

package dbus_uncached_responder_pkg;

  localparam int unsigned c_dbus_trans_width = `DBUS_TRANS_WIDTH;

  typedef logic [31:0] phys_t;
  typedef logic [31:0] uint32_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } dbus_resp_state_t;

  // Loads always fetch the full word; only stores narrow the lanes.
  function automatic logic [3:0] req_byteenable(input logic is_write,
                                                input logic [3:0] be);
    return is_write ? be : 4'hF;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dbus_uncached_responder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dbus_uncached_responder_if                                    |
// | Purpose  : CPU data-bus interface between a MEM-stage master and a       |
// |            responder. Request fields are held stable by the master       |
// |            while stall=1; a request completes when request=1, stall=0.   |
// | Ports    : master -> read, write, invalidate, invalidate_icache,         |
// |                     address, byteenable, wrdata, trans_in               |
// |            slave  -> stall, rddata, trans_out                            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface dbus_uncached_responder_if
  import dbus_uncached_responder_pkg::*;
#(
  parameter int TRANS_WIDTH = c_dbus_trans_width,
  parameter int ADDR_WIDTH  = 32
);

  logic                   read;
  logic                   write;
  logic                   invalidate;
  logic                   invalidate_icache;
  logic [ADDR_WIDTH-1:0]  address;
  logic [3:0]             byteenable;
  logic [31:0]            wrdata;
  logic [TRANS_WIDTH-1:0] trans_in;

  logic                   stall;
  logic [31:0]            rddata;
  logic [TRANS_WIDTH-1:0] trans_out;

  modport master (
    output read, write, invalidate, invalidate_icache,
           address, byteenable, wrdata, trans_in,
    input  stall, rddata, trans_out
  );

  modport slave (
    input  read, write, invalidate, invalidate_icache,
           address, byteenable, wrdata, trans_in,
    output stall, rddata, trans_out
  );

endinterface

`default_nettype wire

// File: rtl/dbus_uncached_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dbus_uncached_responder                                       |
// | Purpose  : Slave end of the CPU data bus for uncached space. Each load   |
// |            or store becomes exactly one transaction on an SRAM-like      |
// |            memory port (req / addr_ok / data_ok) while the CPU is        |
// |            stalled. Cache-maintenance ops complete immediately.          |
// | Ports    : clk, rst          clock, synchronous active-high reset        |
// |            dbus (slave)      CPU data-bus request / response             |
// |            mem_req/wr/addr/be/wdata   memory request (registered)        |
// |            mem_addr_ok/data_ok/rdata  memory handshake and read data     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module dbus_uncached_responder
  import dbus_uncached_responder_pkg::*;
#(
  parameter int TRANS_WIDTH = `DBUS_TRANS_WIDTH,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  dbus_uncached_responder_if.slave dbus,

  output logic                  mem_req,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_addr_ok,
  input  logic                  mem_data_ok,
  input  logic [31:0]           mem_rdata
);

  dbus_resp_state_t       r_state;
  logic                   r_mem_req;
  logic                   r_we;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [3:0]             r_be;
  logic [31:0]            r_wdata;
  logic [TRANS_WIDTH-1:0] r_trans;
  logic [31:0]            r_rddata;

  logic                   w_request;
  logic                   w_unused;

  // Only loads and stores reach memory; invalidates in uncached space have
  // no lines to act on, so they never stall.
  assign w_request = dbus.read | dbus.write;

  // Stall is combinational so a fresh request stalls in its very first
  // cycle, before the FSM has had a chance to latch it.
  assign dbus.stall     = w_request & (r_state != DONE);
  assign dbus.rddata    = r_rddata;
  assign dbus.trans_out = r_trans;

  assign mem_req   = r_mem_req;
  assign mem_wr    = r_we;
  assign mem_addr  = r_addr;
  assign mem_be    = r_be;
  assign mem_wdata = r_wdata;

  // Maintenance flags and the sub-word address bits are intentionally ignored.
  assign w_unused = ^{dbus.invalidate, dbus.invalidate_icache, dbus.address[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_mem_req <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_be      <= 4'h0;
      r_wdata   <= 32'h0;
      r_trans   <= '0;
      r_rddata  <= 32'h0;
    end else begin
      case (r_state)
        IDLE: begin
          // Capture cycle: the request is latched here and issued from REQ
          // so the memory port only ever sees registered fields. A
          // simultaneous read+write is treated as a write.
          if (w_request) begin
            r_we      <= dbus.write;
            r_addr    <= {dbus.address[ADDR_WIDTH-1:2], 2'b00};
            r_be      <= req_byteenable(dbus.write, dbus.byteenable);
            r_wdata   <= dbus.wrdata;
            r_trans   <= dbus.trans_in;
            r_mem_req <= 1'b1;
            r_state   <= REQ;
          end
        end

        REQ: begin
          // data_ok is only meaningful once the address has been accepted.
          if (mem_addr_ok) begin
            r_mem_req <= 1'b0;
            if (mem_data_ok) begin
              if (!r_we) begin
                r_rddata <= mem_rdata;
              end
              r_state <= DONE;
            end else begin
              r_state <= WAIT;
            end
          end
        end

        WAIT: begin
          // Runs to completion even if the master has flushed its request.
          if (mem_data_ok) begin
            if (!r_we) begin
              r_rddata <= mem_rdata;
            end
            r_state <= DONE;
          end
        end

        DONE: begin
          // Single response cycle; a flushed result is simply dropped.
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dbus_uncached_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_dbus_uncached_responder                                    |
// | Purpose  : Directed self-checking bench for dbus_uncached_responder.     |
// |            The bench plays both the CPU master and the memory port.      |
// | Ports    : none                                                          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_dbus_uncached_responder;

    localparam int c_tw      = 4;
    localparam int c_aw      = 32;
    localparam int c_timeout = 100000;

    logic            clk;
    logic            rst;
    logic            mem_req;
    logic            mem_wr;
    logic [c_aw-1:0] mem_addr;
    logic [3:0]      mem_be;
    logic [31:0]     mem_wdata;
    logic            mem_addr_ok;
    logic            mem_data_ok;
    logic [31:0]     mem_rdata;

    int n_asserts = 0;
    int n_fail    = 0;

    dbus_uncached_responder_if #(.TRANS_WIDTH(c_tw), .ADDR_WIDTH(c_aw)) dbus ();

    dbus_uncached_responder #(
        .TRANS_WIDTH (c_tw),
        .ADDR_WIDTH  (c_aw)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .dbus        (dbus.slave),
        .mem_req     (mem_req),
        .mem_wr      (mem_wr),
        .mem_addr    (mem_addr),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .mem_addr_ok (mem_addr_ok),
        .mem_data_ok (mem_data_ok),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #(c_timeout);
        n_fail++;
        $error("FAIL timeout: simulation did not finish within %0d time units", c_timeout);
        $finish;
    end

    initial begin
        rst                    = 1'b1;
        dbus.read              = 1'b0;
        dbus.write             = 1'b0;
        dbus.invalidate        = 1'b0;
        dbus.invalidate_icache = 1'b0;
        dbus.address           = 32'h0;
        dbus.byteenable        = 4'h0;
        dbus.wrdata            = 32'h0;
        dbus.trans_in          = 4'h0;
        mem_addr_ok            = 1'b0;
        mem_data_ok            = 1'b0;
        mem_rdata              = 32'h0;

        // ---------------- reset ----------------
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("rst_stall", dbus.stall, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_rddata", dbus.rddata, 32'h0);
        check("rst_trans_out", dbus.trans_out, 4'h0);

        // ---------------- read, addr_ok in REQ, data_ok next cycle ----------------
        tick();
        dbus.read     = 1'b1;
        dbus.address  = 32'h1FD0_0004;
        dbus.trans_in = 4'd3;
        #1;
        check("rd_idle_stall", dbus.stall, 1'b1);
        check("rd_idle_no_req", mem_req, 1'b0);
        tick();
        mem_addr_ok = 1'b1;
        #1;
        check("rd_req_stall", dbus.stall, 1'b1);
        check("rd_req_mem_req", mem_req, 1'b1);
        check("rd_req_mem_wr", mem_wr, 1'b0);
        check("rd_req_addr", mem_addr, 32'h1FD0_0004);
        check("rd_req_be", mem_be, 4'hF);
        tick();
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'hDEAD_BEEF;
        #1;
        check("rd_wait_stall", dbus.stall, 1'b1);
        check("rd_wait_mem_req", mem_req, 1'b0);
        tick();
        mem_data_ok = 1'b0;
        mem_rdata   = 32'h0;
        #1;
        check("rd_done_stall", dbus.stall, 1'b0);
        check("rd_done_rddata", dbus.rddata, 32'hDEAD_BEEF);
        check("rd_done_trans", dbus.trans_out, 4'd3);
        dbus.read = 1'b0;
        tick();
        #1;
        check("rd_after_stall", dbus.stall, 1'b0);
        check("rd_after_mem_req", mem_req, 1'b0);

        // ---------------- write with 4 cycles of addr_ok=0 ----------------
        dbus.write      = 1'b1;
        dbus.address    = 32'h1FD0_0002;
        dbus.byteenable = 4'b1100;
        dbus.wrdata     = 32'h1234_5678;
        dbus.trans_in   = 4'd5;
        #1;
        check("wr_idle_stall", dbus.stall, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            mem_data_ok = (i == 1);
            mem_rdata   = 32'hFFFF_0000;
            #1;
            check("wr_req_held", mem_req, 1'b1);
            check("wr_req_stall", dbus.stall, 1'b1);
            if (i == 0) begin
                check("wr_mem_wr", mem_wr, 1'b1);
                check("wr_mem_addr", mem_addr, 32'h1FD0_0000);
                check("wr_mem_be", mem_be, 4'b1100);
                check("wr_mem_wdata", mem_wdata, 32'h1234_5678);
            end
        end
        tick();
        mem_addr_ok = 1'b1;
        #1;
        check("wr_req_5th", mem_req, 1'b1);
        tick();
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        #1;
        check("wr_wait_mem_req", mem_req, 1'b0);
        check("wr_wait_stall", dbus.stall, 1'b1);
        tick();
        mem_data_ok = 1'b0;
        #1;
        check("wr_done_stall", dbus.stall, 1'b0);
        check("wr_done_trans", dbus.trans_out, 4'd5);
        check("wr_rddata_held", dbus.rddata, 32'hDEAD_BEEF);
        dbus.write = 1'b0;
        tick();

        // ---------------- read, addr_ok and data_ok together ----------------
        dbus.read     = 1'b1;
        dbus.address  = 32'h1FD0_0008;
        dbus.trans_in = 4'd6;
        #1;
        check("fast_idle_stall", dbus.stall, 1'b1);
        tick();
        mem_addr_ok = 1'b1;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'hA5A5_A5A5;
        #1;
        check("fast_req_stall", dbus.stall, 1'b1);
        check("fast_req_mem_req", mem_req, 1'b1);
        tick();
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = 32'h0;
        #1;
        check("fast_done_stall", dbus.stall, 1'b0);
        check("fast_done_rddata", dbus.rddata, 32'hA5A5_A5A5);
        check("fast_done_trans", dbus.trans_out, 4'd6);
        dbus.read = 1'b0;
        tick();

        // ---------------- cache maintenance only ----------------
        dbus.invalidate = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("inv_stall", dbus.stall, 1'b0);
            check("inv_mem_req", mem_req, 1'b0);
            tick();
        end
        dbus.invalidate        = 1'b0;
        dbus.invalidate_icache = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("iinv_stall", dbus.stall, 1'b0);
            check("iinv_mem_req", mem_req, 1'b0);
            tick();
        end
        dbus.invalidate_icache = 1'b0;

        // ---------------- reset while a read is in WAIT ----------------
        dbus.read     = 1'b1;
        dbus.address  = 32'h1FD0_0010;
        dbus.trans_in = 4'd7;
        tick();
        mem_addr_ok = 1'b1;
        #1;
        check("rstw_req", mem_req, 1'b1);
        tick();
        mem_addr_ok = 1'b0;
        rst         = 1'b1;
        #1;
        check("rstw_wait_stall", dbus.stall, 1'b1);
        tick();
        rst = 1'b0;
        #1;
        check("rstw_mem_req", mem_req, 1'b0);
        check("rstw_rddata", dbus.rddata, 32'h0);
        check("rstw_trans", dbus.trans_out, 4'h0);
        check("rstw_idle_stall", dbus.stall, 1'b1);
        tick();
        mem_addr_ok = 1'b1;
        #1;
        check("rstw_new_req", mem_req, 1'b1);
        check("rstw_new_addr", mem_addr, 32'h1FD0_0010);
        tick();
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h0BAD_F00D;
        tick();
        mem_data_ok = 1'b0;
        mem_rdata   = 32'h0;
        #1;
        check("rstw_done_stall", dbus.stall, 1'b0);
        check("rstw_done_rddata", dbus.rddata, 32'h0BAD_F00D);
        check("rstw_done_trans", dbus.trans_out, 4'd7);
        dbus.read = 1'b0;
        tick();

        // ---------------- flush during WAIT ----------------
        dbus.read     = 1'b1;
        dbus.address  = 32'h1FD0_0020;
        dbus.trans_in = 4'd2;
        tick();
        mem_addr_ok = 1'b1;
        tick();
        mem_addr_ok = 1'b0;
        dbus.read   = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h1111_1111;
        #1;
        check("flush_wait_stall", dbus.stall, 1'b0);
        tick();
        mem_data_ok = 1'b0;
        mem_rdata   = 32'h0;
        #1;
        check("flush_done_stall", dbus.stall, 1'b0);
        check("flush_done_mem_req", mem_req, 1'b0);
        tick();
        dbus.read     = 1'b1;
        dbus.address  = 32'h1FD0_0024;
        dbus.trans_in = 4'd4;
        #1;
        check("flush_next_stall", dbus.stall, 1'b1);
        check("flush_next_idle", mem_req, 1'b0);
        tick();
        mem_addr_ok = 1'b1;
        #1;
        check("flush_next_addr", mem_addr, 32'h1FD0_0024);
        tick();
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h2222_2222;
        #1;
        check("flush_next_wait", dbus.stall, 1'b1);
        tick();
        mem_data_ok = 1'b0;
        mem_rdata   = 32'h0;
        #1;
        check("flush_next_done", dbus.stall, 1'b0);
        check("flush_next_rddata", dbus.rddata, 32'h2222_2222);
        check("flush_next_trans", dbus.trans_out, 4'd4);
        dbus.read = 1'b0;
        tick();
        #1;
        check("final_stall", dbus.stall, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
